// File: rtl/result_encoder_pkg.sv
// Constants and state encoding shared by the calculator's result encoder and input parser.
package result_encoder_pkg;

  localparam logic [3:0] DTYPE_UNSIGNED = 4'h1;
  localparam logic [3:0] DTYPE_SIGNED   = 4'h2;

  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_E     = 8'h45;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h61;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_R,
    ST_HDR_SP,
    ST_SIGN,
    ST_DIGIT,
    ST_ERRC,
    ST_CR,
    ST_LF
  } calc_state_e;

endpackage

// File: rtl/result_encoder_hex2ascii.sv
// Combinational nibble to lowercase ASCII hex digit.
module hex2ascii
  import result_encoder_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) ascii = ASCII_0 + {4'h0, nibble};
    else                ascii = ASCII_A + {4'h0, nibble - 4'd10};
  end

endmodule

// File: rtl/result_encoder.sv
// Formats one calculator result as an ASCII line and streams it over a valid/ready byte port.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | waiting for start, nothing offered
// ST_HDR_R  | offering 'R'
// ST_HDR_SP | offering ' '
// ST_SIGN   | offering '-' for a negative signed result
// ST_DIGIT  | offering hex digit cnt_q of the magnitude
// ST_ERRC   | offering 'E' instead of the result
// ST_CR     | offering carriage return
// ST_LF     | offering line feed, last byte of the frame
module result_encoder
  import result_encoder_pkg::*;
#(
  parameter int unsigned NIB = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NIB-1:0]  result,
  input  logic [3:0]        dtype,
  input  logic              err,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned W  = 4 * NIB;
  localparam int unsigned CW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(NIB - 1);

  calc_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  res_q, res_d;
  logic          err_q, err_d;
  logic          sgn_q, sgn_d;
  logic          done_q, done_d;

  logic          xfer;
  logic          neg;
  logic [W-1:0]  mag;
  logic [3:0]    nibble;
  logic [7:0]    digit_ascii;

  assign xfer = tx_valid && tx_ready;
  assign neg  = sgn_q && res_q[W-1];
  // Two's-complement negate; the most-negative value wraps to itself.
  assign mag  = neg ? (~res_q + 1'b1) : res_q;

  always_comb begin
    nibble = 4'h0;
    for (int i = 0; i < NIB; i++) begin
      if (cnt_q == CW'(i)) nibble = mag[4*i +: 4];
    end
  end

  hex2ascii u_hex2ascii (
    .nibble (nibble),
    .ascii  (digit_ascii)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      sgn_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
      sgn_q   <= sgn_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    sgn_d   = sgn_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_HDR_R;
          res_d   = result;
          err_d   = err;
          sgn_d   = (dtype == DTYPE_SIGNED);
        end
      end
      ST_HDR_R: if (xfer) state_d = ST_HDR_SP;
      ST_HDR_SP: begin
        if (xfer) begin
          if (err_q) begin
            state_d = ST_ERRC;
          end else if (neg) begin
            state_d = ST_SIGN;
          end else begin
            state_d = ST_DIGIT;
            cnt_d   = CNT_TOP;
          end
        end
      end
      ST_SIGN: begin
        if (xfer) begin
          state_d = ST_DIGIT;
          cnt_d   = CNT_TOP;
        end
      end
      ST_DIGIT: begin
        if (xfer) begin
          if (cnt_q == '0) state_d = ST_CR;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_ERRC: if (xfer) state_d = ST_CR;
      ST_CR:   if (xfer) state_d = ST_LF;
      ST_LF: begin
        if (xfer) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_data  = 8'h00;
    tx_valid = (state_q != ST_IDLE);
    busy     = (state_q != ST_IDLE);
    case (state_q)
      ST_HDR_R:  tx_data = ASCII_R;
      ST_HDR_SP: tx_data = ASCII_SP;
      ST_SIGN:   tx_data = ASCII_MINUS;
      ST_DIGIT:  tx_data = digit_ascii;
      ST_ERRC:   tx_data = ASCII_E;
      ST_CR:     tx_data = ASCII_CR;
      ST_LF:     tx_data = ASCII_LF;
      default:   tx_data = 8'h00;
    endcase
  end

  assign done = done_q;

endmodule

// File: tb/tb_result_encoder.sv
// Scoreboard bench for result_encoder: expected frames are queued by the driver, a monitor pops on each transfer.
module tb_result_encoder;
  import result_encoder_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] result;
  logic [3:0]  dtype;
  logic        err;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;
  int xfer_cnt = 0;
  bit prev_lf  = 0;
  logic [7:0] exp_q[$];

  result_encoder #(.NIB(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .result   (result),
    .dtype    (dtype),
    .err      (err),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_lf = 0;
      end else begin
        if (prev_lf) begin
          chk("done_pulse", {31'b0, done}, 32'd1);
          chk("busy_after_lf", {31'b0, busy}, 32'd0);
        end else if (done) begin
          chk("spurious_done", {31'b0, done}, 32'd0);
        end
        prev_lf = 0;
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte actual=%h required=none", tx_data);
          end else begin
            e = exp_q.pop_front();
            chk("tx_byte", {24'b0, tx_data}, {24'b0, e});
          end
          chk("busy_in_frame", {31'b0, busy}, 32'd1);
          xfer_cnt++;
          if (tx_data == ASCII_LF) prev_lf = 1;
        end
      end
    end
  endtask

  task automatic push_frame(input string body);
    for (int i = 0; i < body.len(); i++) exp_q.push_back(body[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Driver must be called at posedge+1.
  task automatic run_frame(input logic [31:0] r, input logic [3:0] dt, input logic e,
                           input string body, input bit stall, input bit mid);
    int n, base, cyc;
    bit stalled;
    logic [7:0] held;
    push_frame(body);
    n = body.len() + 2;
    base = xfer_cnt;
    stalled = 0;
    result = r; dtype = dt; err = e; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; result = 32'h5A5A_A5A5; dtype = DTYPE_SIGNED; err = ~e;
    chk("first_valid", {31'b0, tx_valid}, 32'd1);
    chk("first_byte", {24'b0, tx_data}, 32'h52);
    cyc = 0;
    while (!done && cyc < 100) begin
      if (stall && !stalled && (xfer_cnt - base) == 4) begin
        stalled = 1;
        tx_ready = 1'b0;
        held = tx_data;
        repeat (5) begin
          @(negedge clk);
          chk("stall_valid", {31'b0, tx_valid}, 32'd1);
          chk("stall_data", {24'b0, tx_data}, {24'b0, held});
          @(posedge clk); #1;
          cyc++;
        end
        tx_ready = 1'b1;
      end
      if (mid && cyc == 3) begin
        start = 1'b1; result = 32'hFFFF_FFFF; dtype = DTYPE_SIGNED; err = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", {31'b0, done}, 32'd1);
    chk("frame_cycles", cyc, n + (stall ? 5 : 0));
    chk("xfer_count", xfer_cnt - base, n);
    chk("queue_empty", exp_q.size(), 0);
    dtype = DTYPE_UNSIGNED; err = 1'b0;
  endtask

  task automatic reset_mid_frame();
    int base, cyc;
    push_frame("R 00001234");
    base = xfer_cnt;
    result = 32'h0000_1234; dtype = DTYPE_UNSIGNED; err = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while ((xfer_cnt - base) != 4 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rst_at_byte5", xfer_cnt - base, 4);
    rst = 1'b1; tx_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'h00);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    rst = 1'b0; tx_ready = 1'b1;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", {31'b0, tx_valid}, 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; result = '0; dtype = DTYPE_UNSIGNED; err = 1'b0; tx_ready = 1'b1;
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("reset_tx_data", {24'b0, tx_data}, 32'h00);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_frame(32'h0000_1234, DTYPE_UNSIGNED, 1'b0, "R 00001234", 0, 0);
    run_frame(32'hFFFF_FFFE, DTYPE_SIGNED,   1'b0, "R -00000002", 0, 0);
    run_frame(32'h8000_0000, DTYPE_SIGNED,   1'b0, "R -80000000", 0, 0);
    run_frame(32'hDEAD_BEEF, DTYPE_UNSIGNED, 1'b0, "R deadbeef", 0, 0);
    run_frame(32'h7FFF_FFFF, DTYPE_SIGNED,   1'b0, "R 7fffffff", 0, 0);
    run_frame(32'h1234_5678, DTYPE_SIGNED,   1'b1, "R E", 0, 0);
    run_frame(32'h8000_0001, 4'h7,           1'b0, "R 80000001", 0, 0);
    run_frame(32'h0000_1234, DTYPE_UNSIGNED, 1'b0, "R 00001234", 1, 0);
    run_frame(32'h00AB_CDEF, DTYPE_UNSIGNED, 1'b0, "R 00abcdef", 0, 1);
    reset_mid_frame();
    run_frame(32'h0000_0001, DTYPE_UNSIGNED, 1'b0, "R 00000001", 0, 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_encoder.md
RESULT_ENCODER -- requirements
Module: result_encoder

Interface
REQ-001 Parameter: NIB, 8, number of hex digits emitted; result width is 4*NIB bits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  one-cycle request to format and send one result.
REQ-005 result  input  4*NIB  calculator result, sampled when start is accepted.
REQ-006 dtype  input  4  4'h1 unsigned, 4'h2 signed; any other value is treated as unsigned.
REQ-007 err  input  1  error flag (e.g. divide by zero), sampled with result.
REQ-008 tx_data  output  8  ASCII byte offered to the UART transmitter.
REQ-009 tx_valid  output  1  tx_data is valid.
REQ-010 tx_ready  input  1  UART transmitter accepts the byte this cycle.
REQ-011 busy  output  1  a frame is in progress.
REQ-012 done  output  1  one-cycle pulse after the final byte is accepted.

Function
REQ-013 start is accepted only in IDLE; start while busy=1 shall be ignored with no effect.
REQ-014 On acceptance, result, err and signed=(dtype==4'h2) shall be registered; tx_valid shall rise on the next cycle with tx_data=8'h52 ('R').
REQ-015 Frame, unsigned or non-negative: 'R'(52) ' '(20), then NIB hex digits, MSB first, CR(0D) LF(0A).
REQ-016 Frame, signed with result MSB=1: 'R' ' ' '-'(2D), then NIB digits of the two's-complement magnitude, then CR LF.
REQ-017 Frame, err=1: 'R' ' ' 'E'(45) CR LF; result is not emitted.
REQ-018 Digits: 0-9 map to 30-39; a-f map to lowercase 61-66. Leading zeros are always emitted, so the digit count is fixed at NIB.
REQ-019 Negating the most-negative value (e.g. 80000000) wraps to itself and shall emit "-80000000".
REQ-020 Handshake: a byte transfers when tx_valid&&tx_ready at a rising edge. Until that transfer, tx_valid shall stay high and tx_data shall stay stable. The next byte, or deassertion, follows on the next cycle, with no idle gap between bytes.
REQ-021 tx_ready while tx_valid=0 shall have no effect.
REQ-022 States: IDLE, HDR_R, HDR_SP, SIGN, DIGIT, ERRC, CR, LF.
  - HDR_SP goes to ERRC if err, else SIGN if negative signed, else DIGIT.
  - SIGN goes to DIGIT.
  - DIGIT repeats NIB times via a down-counter from NIB-1 to 0, then goes to CR.
  - ERRC goes to CR; CR goes to LF; LF goes to IDLE.
  - Every transition out of a state shall occur only on a transfer.
REQ-023 done shall pulse in the cycle after the LF transfer, coincident with the return to IDLE and busy=0; a new start is accepted in that same cycle.
REQ-024 busy shall be 1 from the cycle after acceptance through the LF transfer cycle.

Reset
REQ-025 rst=1 at a rising edge shall force: state IDLE, tx_valid=0, tx_data=8'h00, busy=0, done=0, digit counter 0, captured registers 0.
REQ-026 Reset mid-frame shall abort the frame immediately with no further bytes; the next start after reset shall emit a complete frame.

Structure
REQ-027 The shared calc package shall hold:
  - dtype codes (4'h1 unsigned, 4'h2 signed);
  - ASCII constants (R, space, minus, E, CR, LF, 0x30, 0x61);
  - the state encoding, shared with the input parser.
REQ-028 One sub-module, hex2ascii, shall hold the combinational mapping from a 4-bit nibble to its ASCII byte. All sequential logic shall stay in result_encoder.

Verification
REQ-029 Unsigned 0x00001234, tx_ready=1 -> bytes 52 20 30 30 30 30 31 32 33 34 0D 0A on consecutive cycles; done one cycle after 0A.
REQ-030 Signed 0xFFFFFFFE -> 52 20 2D 30 30 30 30 30 30 30 32 0D 0A. Signed 0x80000000 -> 52 20 2D 38 30 30 30 30 30 30 30 0D 0A.
REQ-031 Unsigned 0xDEADBEEF -> digits 64 65 61 64 62 65 65 66. dtype=4'h2 with 0x7FFFFFFF -> no '-', digits 37 66 66 66 66 66 66 66.
REQ-032 err=1, any result -> 52 20 45 0D 0A, then done.
REQ-033 tx_ready held low 5 cycles while the 3rd digit is offered -> tx_data and tx_valid stable throughout; no byte dropped or duplicated; total 12 transfers.
REQ-034 start pulsed mid-frame -> ignored and the frame is unchanged. rst during the 5th byte -> tx_valid=0 next cycle; a subsequent start with 0x1 emits the full 12-byte frame.
